// File: rtl/prescaler_multi.sv
// Purpose : N-channel programmable clock divider with square wave, tick and shadowed reload.
// Latency : outputs registered, one cycle behind the counter value that produced them.
// Backpres: none; i_Load is a fire-and-forget strobe and the last write before apply wins.
//
// Ports:
//   i_Clk            system clock, rising edge
//   i_Rst            asynchronous reset, active low
//   i_En[N_CH]       per-channel run enable
//   i_Load           one-cycle strobe writing i_Period/i_High into the shadow of channel i_Sel
//   i_Sel            target channel for i_Load (values >= N_CH are ignored)
//   i_Period/i_High  new period / high time in clock cycles
//   i_Sync           (only with PRESC_SYNC_EN) restart every running channel at cnt=0
//   o_Pend[N_CH]     shadow written but not yet applied
//   o_Presc[N_CH]    divided square wave
//   o_Tick[N_CH]     one-cycle pulse at the end of each period
//
// Optional feature macro: PRESC_SYNC_EN (adds i_Sync phase-alignment input).

module prescaler_multi #(
  parameter int          N_CH       = 4,
  parameter int          CNT_W      = 20,
  parameter int unsigned DEF_PERIOD = 833334,
  parameter int unsigned DEF_HIGH   = 416667,
  localparam int         SEL_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic [N_CH-1:0]  i_En,
  input  logic             i_Load,
  input  logic [SEL_W-1:0] i_Sel,
  input  logic [CNT_W-1:0] i_Period,
  input  logic [CNT_W-1:0] i_High,
`ifdef PRESC_SYNC_EN
  input  logic             i_Sync,
`endif
  output logic [N_CH-1:0]  o_Pend,
  output logic [N_CH-1:0]  o_Presc,
  output logic [N_CH-1:0]  o_Tick
);

  logic sync;
`ifdef PRESC_SYNC_EN
  assign sync = i_Sync;
`else
  assign sync = 1'b0;
`endif

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] p_q;
    logic [CNT_W-1:0] h_q;
    logic [CNT_W-1:0] sp_q;
    logic [CNT_W-1:0] sh_q;
    logic             pend_q;
    logic             presc_q;
    logic             tick_q;
    logic             run;
    logic             wrap;
    logic             load_hit;
    logic [CNT_W-1:0] h_eff;

    // A zero period parks the channel exactly like a cleared enable.
    assign run      = i_En[c] && (p_q != '0);
    assign wrap     = (cnt_q == p_q - CNT_W'(1));
    // i_Sel never matches an out-of-range value, so those strobes fall through.
    assign load_hit = i_Load && (i_Sel == SEL_W'(c));
    // High time that will be in force after this edge (a pending shadow lands now on sync).
    assign h_eff    = pend_q ? sh_q : h_q;

    always_ff @(posedge i_Clk or negedge i_Rst) begin
      if (!i_Rst) begin
        cnt_q   <= '0;
        p_q     <= CNT_W'(DEF_PERIOD);
        h_q     <= CNT_W'(DEF_HIGH);
        sp_q    <= CNT_W'(DEF_PERIOD);
        sh_q    <= CNT_W'(DEF_HIGH);
        pend_q  <= 1'b0;
        presc_q <= 1'b0;
        tick_q  <= 1'b0;
      end else begin
        if (!run) begin
          // Idle: nothing mid-period to protect, so a pending shadow applies at once.
          cnt_q   <= '0;
          presc_q <= 1'b0;
          tick_q  <= 1'b0;
          if (pend_q) begin
            p_q    <= sp_q;
            h_q    <= sh_q;
            pend_q <= 1'b0;
          end
        end else if (sync) begin
          cnt_q   <= '0;
          tick_q  <= 1'b0;
          presc_q <= (h_eff != '0);
          if (pend_q) begin
            p_q    <= sp_q;
            h_q    <= sh_q;
            pend_q <= 1'b0;
          end
        end else begin
          presc_q <= (cnt_q < h_q);
          tick_q  <= wrap;
          cnt_q   <= wrap ? '0 : cnt_q + CNT_W'(1);
          // Apply only on the wrap so the running period is never cut short.
          if (wrap && pend_q) begin
            p_q    <= sp_q;
            h_q    <= sh_q;
            pend_q <= 1'b0;
          end
        end
        // Placed last so a load coinciding with an apply keeps the new value pending.
        if (load_hit) begin
          sp_q   <= i_Period;
          sh_q   <= i_High;
          pend_q <= 1'b1;
        end
      end
    end

    assign o_Pend[c]  = pend_q;
    assign o_Presc[c] = presc_q;
    assign o_Tick[c]  = tick_q;
  end

endmodule

// File: tb/tb_prescaler_multi.sv
// Purpose : directed self-checking bench for prescaler_multi (small reset defaults).
// Latency : outputs sampled 1 ns after each rising edge.
// Backpres: n/a.

module tb_prescaler_multi;

  localparam int N_CH  = 3;
  localparam int CNT_W = 20;
  localparam int DEF_P = 12;
  localparam int DEF_H = 5;

  logic             i_Clk;
  logic             i_Rst;
  logic [N_CH-1:0]  i_En;
  logic             i_Load;
  logic [1:0]       i_Sel;
  logic [CNT_W-1:0] i_Period;
  logic [CNT_W-1:0] i_High;
`ifdef PRESC_SYNC_EN
  logic             i_Sync;
`endif
  logic [N_CH-1:0]  o_Pend;
  logic [N_CH-1:0]  o_Presc;
  logic [N_CH-1:0]  o_Tick;

  int n_tests = 0;
  int n_fail  = 0;

  prescaler_multi #(
    .N_CH      (N_CH),
    .CNT_W     (CNT_W),
    .DEF_PERIOD(DEF_P),
    .DEF_HIGH  (DEF_H)
  ) dut (
    .i_Clk   (i_Clk),
    .i_Rst   (i_Rst),
    .i_En    (i_En),
    .i_Load  (i_Load),
    .i_Sel   (i_Sel),
    .i_Period(i_Period),
    .i_High  (i_High),
`ifdef PRESC_SYNC_EN
    .i_Sync  (i_Sync),
`endif
    .o_Pend  (o_Pend),
    .o_Presc (o_Presc),
    .o_Tick  (o_Tick)
  );

  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge i_Clk);
    #1;
  endtask

  // Runs n edges, gathering statistics on channel ch; i_Load drops after the first edge.
  task automatic measure(input int ch, input int n, output int ticks, output int highs,
                         output int first_t, output int last_t, output int pends,
                         output int others);
    ticks = 0; highs = 0; pends = 0; others = 0; first_t = -1; last_t = -1;
    for (int k = 1; k <= n; k++) begin
      step();
      i_Load = 1'b0;
      if (o_Tick[ch]) begin
        ticks++;
        if (first_t < 0) first_t = k;
        last_t = k;
      end
      if (o_Presc[ch]) highs++;
      if (o_Pend[ch])  pends++;
      for (int j = 0; j < N_CH; j++)
        if (j != ch && (o_Presc[j] || o_Tick[j])) others++;
    end
  endtask

  // Loads P/H into an idle channel, lets it apply, then enables it.
  task automatic cfg(input int ch, input int p, input int h);
    i_En[ch] = 1'b0;
    i_Sel    = 2'(ch);
    i_Period = CNT_W'(p);
    i_High   = CNT_W'(h);
    i_Load   = 1'b1;
    step();
    i_Load   = 1'b0;
    step();
    i_En[ch] = 1'b1;
  endtask

  initial begin
    int tk, hi, ft, lt, pd, ot;
    i_Rst = 1'b0; i_En = '0; i_Load = 1'b0; i_Sel = '0; i_Period = '0; i_High = '0;
`ifdef PRESC_SYNC_EN
    i_Sync = 1'b0;
`endif
    repeat (3) step();
    check("rst_presc", int'(o_Presc), 0);
    check("rst_tick",  int'(o_Tick),  0);
    check("rst_pend",  int'(o_Pend),  0);

    // Defaults on ch0: period 12, high 5.
    i_Rst = 1'b1;
    i_En  = 3'b001;
    measure(0, 36, tk, hi, ft, lt, pd, ot);
    check("def_first_tick", ft, 12);
    check("def_ticks",      tk, 3);
    check("def_last_tick",  lt, 36);
    check("def_highs",      hi, 15);
    check("def_others",     ot, 0);

    // Load ch1 P=10 H=3 while idle, then run.
    i_Sel = 2'd1; i_Period = 20'd10; i_High = 20'd3; i_Load = 1'b1;
    step();
    i_Load = 1'b0;
    check("ld_pend_set", int'(o_Pend[1]), 1);
    step();
    check("ld_pend_clr", int'(o_Pend[1]), 0);
    i_En[1] = 1'b1;
    measure(1, 30, tk, hi, ft, lt, pd, ot);
    check("p10_first_tick", ft, 10);
    check("p10_ticks",      tk, 3);
    check("p10_highs",      hi, 9);

    // Reload P=4 H=2 landing when cnt becomes 5; current 10-cycle period must finish.
    repeat (4) step();
    i_Sel = 2'd1; i_Period = 20'd4; i_High = 20'd2; i_Load = 1'b1;
    measure(1, 18, tk, hi, ft, lt, pd, ot);
    check("rl_first_tick", ft, 6);
    check("rl_ticks",      tk, 4);
    check("rl_last_tick",  lt, 18);
    check("rl_highs",      hi, 6);
    check("rl_pend_cyc",   pd, 5);

    // Out-of-range select is ignored.
    i_Sel = 2'd3; i_Period = 20'd7; i_High = 20'd1; i_Load = 1'b1;
    step();
    i_Load = 1'b0;
    check("bad_sel_pend", int'(o_Pend), 0);

    // Duty/period boundaries on ch2.
    cfg(2, 5, 0);
    measure(2, 10, tk, hi, ft, lt, pd, ot);
    check("h0_highs", hi, 0);
    check("h0_ticks", tk, 2);
    check("h0_first", ft, 5);
    cfg(2, 5, 7);
    measure(2, 10, tk, hi, ft, lt, pd, ot);
    check("hbig_highs", hi, 10);
    check("hbig_ticks", tk, 2);
    i_En[2] = 1'b0;
    step();
    check("dis_presc", int'(o_Presc[2]), 0);
    cfg(2, 1, 0);
    measure(2, 10, tk, hi, ft, lt, pd, ot);
    check("p1_ticks", tk, 10);
    check("p1_first", ft, 1);
    cfg(2, 0, 3);
    measure(2, 10, tk, hi, ft, lt, pd, ot);
    check("p0_ticks", tk, 0);
    check("p0_highs", hi, 0);

    // Reset mid-period on ch0 with cnt=3 and a pending P=7 H=2.
    i_En[0] = 1'b0;
    step();
    i_En[0] = 1'b1;
    step();
    step();
    i_Sel = 2'd0; i_Period = 20'd7; i_High = 20'd2; i_Load = 1'b1;
    step();
    i_Load = 1'b0;
    check("pre_rst_pend", int'(o_Pend[0]), 1);
    #2;
    i_Rst = 1'b0;
    #1;
    check("arst_presc", int'(o_Presc), 0);
    check("arst_tick",  int'(o_Tick),  0);
    check("arst_pend",  int'(o_Pend),  0);
    i_En = 3'b001;
    step();
    step();
    i_Rst = 1'b1;
    measure(0, 12, tk, hi, ft, lt, pd, ot);
    check("post_rst_first", ft, 12);
    check("post_rst_ticks", tk, 1);
    check("post_rst_highs", hi, 5);

`ifdef PRESC_SYNC_EN
    begin
      int f0, f1, nc, lc;
      cfg(0, 6, 3);
      cfg(1, 9, 3);
      repeat (3) step();
      i_Sync = 1'b1;
      step();
      i_Sync = 1'b0;
      check("sync_tick",  int'(o_Tick[1:0]),  0);
      check("sync_presc", int'(o_Presc[1:0]), 3);
      f0 = -1; f1 = -1; nc = 0; lc = -1;
      for (int k = 1; k <= 18; k++) begin
        step();
        if (o_Tick[0] && f0 < 0) f0 = k;
        if (o_Tick[1] && f1 < 0) f1 = k;
        if (o_Tick[0] && o_Tick[1]) begin
          nc++;
          lc = k;
        end
      end
      check("sync_first0",  f0, 6);
      check("sync_first1",  f1, 9);
      check("sync_common",  nc, 1);
      check("sync_common_at", lc, 18);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
